// File: rtl/mult_div_pkg.sv
// Shared op encodings, FSM state type and sizing helper for the multiply/divide unit.
package mult_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    // One extra bit so the counter can reach DATA_WIDTH itself without wrapping.
    function automatic int counterWidth(input int dataWidth);
        return $clog2(dataWidth) + 1;
    endfunction

endpackage

// File: rtl/mult_div_unit_twos_negate.sv
// Combinational two's-complement negation, used for operand magnitudes and result sign fixup.
module twos_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = ~i_value + WIDTH'(1);

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Signed MULT/DIV support is built only when MULT_DIV_SIGNED_EN is defined.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  hiWrite,
    input  logic                  loWrite,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic                  busy,
    output logic                  done,
    output logic                  divByZero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = counterWidth(DATA_WIDTH);

    state_t           r_state;
    state_t           w_nextState;
    logic             r_busy;
    logic             r_done;
    logic             r_divByZero;
    logic             r_isDiv;
    logic             r_divZero;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;
    logic [W-1:0]     r_operand;
    logic [2*W-1:0]   r_acc;
    logic [W:0]       r_rem;
    logic [CNT_W-1:0] r_count;

    logic             w_startDiv;
    logic [W-1:0]     w_opA;
    logic [W-1:0]     w_opB;
    logic [W:0]       w_mulSum;
    logic [W:0]       w_partial;
    logic [W:0]       w_trial;
    logic             w_geq;
    logic [W-1:0]     w_resHi;
    logic [W-1:0]     w_resLo;

    assign w_startDiv = (op == OP_DIV) || (op == OP_DIVU);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (r_count == CNT_W'(W - 1)) w_nextState = FINISH;
            FINISH:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Multiply: LSB of the accumulator selects whether the multiplicand joins the upper half.
    assign w_mulSum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_operand} : '0);
    // Divide: dividend bits leave the top of the quotient field and enter the partial remainder.
    assign w_partial = {r_rem[W-1:0], r_acc[W-1]};
    assign w_trial   = w_partial - {1'b0, r_operand};
    assign w_geq     = r_rem[W] | (w_partial >= {1'b0, r_operand});

`ifdef MULT_DIV_SIGNED_EN
    logic           w_signedOp;
    logic           r_negRes;
    logic           r_negRem;
    logic [W-1:0]   w_negA;
    logic [W-1:0]   w_negB;
    logic [W-1:0]   w_negQuot;
    logic [W-1:0]   w_negRem;
    logic [2*W-1:0] w_negProd;

    assign w_signedOp = (op == OP_MULT) || (op == OP_DIV);

    twos_negate #(.WIDTH(W))     uNegA    (.i_value(a),              .o_value(w_negA));
    twos_negate #(.WIDTH(W))     uNegB    (.i_value(b),              .o_value(w_negB));
    twos_negate #(.WIDTH(2*W))   uNegProd (.i_value(r_acc),          .o_value(w_negProd));
    twos_negate #(.WIDTH(W))     uNegQuot (.i_value(r_acc[W-1:0]),   .o_value(w_negQuot));
    twos_negate #(.WIDTH(W))     uNegRem  (.i_value(r_rem[W-1:0]),   .o_value(w_negRem));

    assign w_opA = (w_signedOp && a[W-1]) ? w_negA : a;
    assign w_opB = (w_signedOp && b[W-1]) ? w_negB : b;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_negRes <= 1'b0;
            r_negRem <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_negRes <= w_signedOp && (a[W-1] ^ b[W-1]);
            r_negRem <= w_signedOp && a[W-1];
        end
    end

    // Divide-by-zero still yields the negated |a| in HI, which restores the original dividend.
    always_comb begin
        w_resHi = '0;
        w_resLo = '0;
        if (r_isDiv) begin
            w_resHi = r_negRem ? w_negRem : r_rem[W-1:0];
            w_resLo = r_divZero ? '1 : (r_negRes ? w_negQuot : r_acc[W-1:0]);
        end else begin
            w_resHi = r_negRes ? w_negProd[2*W-1:W] : r_acc[2*W-1:W];
            w_resLo = r_negRes ? w_negProd[W-1:0]   : r_acc[W-1:0];
        end
    end
`else
    assign w_opA = a;
    assign w_opB = b;

    always_comb begin
        w_resHi = '0;
        w_resLo = '0;
        if (r_isDiv) begin
            w_resHi = r_rem[W-1:0];
            w_resLo = r_divZero ? '1 : r_acc[W-1:0];
        end else begin
            w_resHi = r_acc[2*W-1:W];
            w_resLo = r_acc[W-1:0];
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_divByZero <= 1'b0;
            r_isDiv     <= 1'b0;
            r_divZero   <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_operand   <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_count     <= '0;
        end else begin
            r_done      <= 1'b0;
            r_divByZero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hiWrite) r_hi <= writeData;
                    if (loWrite) r_lo <= writeData;
                    if (start) begin
                        r_busy    <= 1'b1;
                        r_isDiv   <= w_startDiv;
                        r_divZero <= w_startDiv && (b == '0);
                        r_operand <= w_startDiv ? w_opB : w_opA;
                        r_acc     <= {{W{1'b0}}, (w_startDiv ? w_opA : w_opB)};
                        r_rem     <= '0;
                        r_count   <= '0;
                    end
                end
                RUN: begin
                    r_count <= r_count + CNT_W'(1);
                    if (r_isDiv) begin
                        r_acc <= {r_acc[2*W-1:W], r_acc[W-2:0], w_geq};
                        r_rem <= w_geq ? w_trial : w_partial;
                    end else begin
                        r_acc <= {w_mulSum, r_acc[W-1:1]};
                    end
                end
                FINISH: begin
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_divByZero <= r_divZero;
                    r_hi        <= w_resHi;
                    r_lo        <= w_resLo;
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign divByZero = r_divByZero;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO, a monitor checks each done pulse.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hiWrite;
    logic         loWrite;
    logic [W-1:0] writeData;
    logic         busy;
    logic         done;
    logic         divByZero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } expect_t;

    expect_t scoreboard[$];
    expect_t monExp;
    int      checks = 0;
    int      errors = 0;
    int      cycles;

    mult_div_unit #(.DATA_WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .hiWrite   (hiWrite),
        .loWrite   (loWrite),
        .writeData (writeData),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Called at a negedge with the unit idle; returns one negedge after start was sampled.
    task automatic applyStimulus(input string name, input logic [1:0] opIn, input logic [W-1:0] aIn,
                                 input logic [W-1:0] bIn, input logic [W-1:0] expHi,
                                 input logic [W-1:0] expLo, input logic expDbz, input bit track);
        expect_t e;
        e.name = name;
        e.hi   = expHi;
        e.lo   = expLo;
        e.dbz  = expDbz;
        if (track) scoreboard.push_back(e);
        op    = opIn;
        a     = aIn;
        b     = bIn;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int limit, output int count);
        count = 1;
        while (done !== 1'b1 && count < limit) begin
            @(negedge clock);
            count++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s.doneTimeout actual=no done expected=done within %0d cycles", name, limit);
        end
    endtask

    task automatic runOp(input string name, input logic [1:0] opIn, input logic [W-1:0] aIn,
                         input logic [W-1:0] bIn, input logic [W-1:0] expHi,
                         input logic [W-1:0] expLo, input logic expDbz);
        int n;
        applyStimulus(name, opIn, aIn, bIn, expHi, expLo, expDbz, 1'b1);
        waitDone(name, 60, n);
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (scoreboard.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone actual=done expected=no done");
            end else begin
                monExp = scoreboard.pop_front();
                checkOutput({monExp.name, ".hi"}, hi, monExp.hi);
                checkOutput({monExp.name, ".lo"}, lo, monExp.lo);
                checkOutput({monExp.name, ".divByZero"}, {31'b0, divByZero}, {31'b0, monExp.dbz});
                checkOutput({monExp.name, ".busyAtDone"}, {31'b0, busy}, 32'd0);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op        = OP_MULTU;
        a         = '0;
        b         = '0;
        hiWrite   = 1'b0;
        loWrite   = 1'b0;
        writeData = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset.hi", hi, 32'd0);
        checkOutput("reset.lo", lo, 32'd0);
        checkOutput("reset.busy", {31'b0, busy}, 32'd0);
        checkOutput("reset.done", {31'b0, done}, 32'd0);
        checkOutput("reset.divByZero", {31'b0, divByZero}, 32'd0);

        applyStimulus("multuMax", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
        checkOutput("multuMax.busyAfterStart", {31'b0, busy}, 32'd1);
        waitDone("multuMax", 60, cycles);
        checkOutput("multuMax.latency", 32'(cycles), 32'd34);

`ifdef MULT_DIV_SIGNED_EN
        runOp("multNeg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        runOp("mult5xNeg4", OP_MULT, 32'd5, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0);
        runOp("divNeg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        runOp("div7byNeg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        runOp("divOverflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
`else
        runOp("multNeg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'd6, 32'hFFFF_FFEB, 1'b0);
        runOp("mult5xNeg4", OP_MULT, 32'd5, 32'hFFFF_FFFC, 32'd4, 32'hFFFF_FFEC, 1'b0);
        runOp("divNeg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0);
        runOp("div7byNeg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd0, 1'b0);
        runOp("divOverflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
`endif
        runOp("divuByZero", OP_DIVU, 32'd123, 32'd0, 32'd123, 32'hFFFF_FFFF, 1'b1);
        runOp("divu100by7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        runOp("multuShift", OP_MULTU, 32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780, 1'b0);

        applyStimulus("busyIgnore", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);
        repeat (4) @(negedge clock);
        checkOutput("busyIgnore.busyMid", {31'b0, busy}, 32'd1);
        start     = 1'b1;
        op        = OP_DIVU;
        a         = 32'd1;
        b         = 32'd1;
        hiWrite   = 1'b1;
        writeData = 32'h55;
        @(negedge clock);
        start   = 1'b0;
        hiWrite = 1'b0;
        waitDone("busyIgnore", 60, cycles);
        loWrite   = 1'b1;
        writeData = 32'hAA;
        @(negedge clock);
        loWrite = 1'b0;
        checkOutput("mtlo.lo", lo, 32'hAA);
        checkOutput("mtlo.hi", hi, 32'd0);
        checkOutput("busyIgnore.notQueued", {31'b0, busy}, 32'd0);

        applyStimulus("abort", OP_MULTU, 32'hFFFF, 32'hFFFF, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort.busy", {31'b0, busy}, 32'd0);
        checkOutput("abort.hi", hi, 32'd0);
        checkOutput("abort.lo", lo, 32'd0);
        checkOutput("abort.done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        checkOutput("abort.staysIdle", {31'b0, busy}, 32'd0);

        runOp("multu6x7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        @(negedge clock);
        checkOutput("scoreboardEmpty", 32'(scoreboard.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
